key_event: RTL and testbench



---
 rtl/key_event.sv | 127 ++++++++++++
 tb/tb_key_event.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_event.sv
// key_event: turns a debounced key level into single-cycle press, release,
// long-press and auto-repeat pulses, plus a registered "held" level.
// Long-press and repeat timing is measured in prescaler ticks (one every
// 2^TICK_N clocks), so thresholds are quantised to whole ticks.

module key_event #(
    parameter int unsigned TICK_N       = 20,
    parameter int unsigned LONG_TICKS   = 30,
    parameter int unsigned REPEAT_TICKS = 8,
    parameter int unsigned REPEAT_EN    = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_mark,
    output logic press_tick,
    output logic release_tick,
    output logic long_tick,
    output logic repeat_tick,
    output logic held
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPressed = 2'd1,
        StLong    = 2'd2
    } state_e;

    localparam logic [7:0] LongLast   = 8'(LONG_TICKS - 1);
    localparam logic [7:0] RepeatLast = 8'(REPEAT_TICKS - 1);
    localparam logic       RepeatOn   = (REPEAT_EN != 0);

    logic [TICK_N-1:0] presc_q;
    logic              key_q;
    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              press_d, release_d, long_d, repeat_d, held_d;
    logic              tick, rise, fall;

    assign tick = &presc_q;
    assign rise = key_mark & ~key_q;
    assign fall = ~key_mark & key_q;

    // Free-running prescaler and one-clock-delayed copy of the key level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            key_q   <= 1'b0;
        end else begin
            presc_q <= presc_q + TICK_N'(1);
            key_q   <= key_mark;
        end
    end

    // Next-state, hold counter and pulse decisions; fall always beats tick.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            StIdle: begin
                // A tick coinciding with the rise is deliberately not counted.
                if (rise) begin
                    press_d = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = StPressed;
                end
            end
            StPressed: begin
                if (fall) begin
                    release_d = 1'b1;
                    state_d   = StIdle;
                end else if (tick) begin
                    if (cnt_q == LongLast) begin
                        long_d  = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = StLong;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            StLong: begin
                if (fall) begin
                    release_d = 1'b1;
                    state_d   = StIdle;
                end else if (tick) begin
                    if (cnt_q == RepeatLast) begin
                        repeat_d = RepeatOn;
                        cnt_d    = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 8'd0;
            end
        endcase
        held_d = (state_d == StPressed) || (state_d == StLong);
    end

    // State, counter and registered outputs; reset drops every pulse at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= 8'd0;
            press_tick   <= 1'b0;
            release_tick <= 1'b0;
            long_tick    <= 1'b0;
            repeat_tick  <= 1'b0;
            held         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            press_tick   <= press_d;
            release_tick <= release_d;
            long_tick    <= long_d;
            repeat_tick  <= repeat_d;
            held         <= held_d;
        end
    end

endmodule

// File: tb/tb_key_event.sv
// Bench for key_event: two instances (auto-repeat on and off) share one key
// stream; a tick-counting model predicts every output on every clock, and
// directed holds pin the model with hand-computed pulse timings.

module tb_key_event;

    localparam int unsigned TN     = 3;
    localparam int unsigned LT     = 4;
    localparam int unsigned RT     = 2;
    localparam int          Period = 1 << TN;

    logic clk = 1'b0;
    logic reset;
    logic key_mark;
    logic pa, ra, la, rpa, ha;
    logic pb, rb, lb, rpb, hb;

    always #5 clk = ~clk;

    key_event #(.TICK_N(TN), .LONG_TICKS(LT), .REPEAT_TICKS(RT), .REPEAT_EN(1)) dut_a (
        .clk(clk), .reset(reset), .key_mark(key_mark),
        .press_tick(pa), .release_tick(ra), .long_tick(la), .repeat_tick(rpa), .held(ha)
    );

    key_event #(.TICK_N(TN), .LONG_TICKS(LT), .REPEAT_TICKS(RT), .REPEAT_EN(0)) dut_b (
        .clk(clk), .reset(reset), .key_mark(key_mark),
        .press_tick(pb), .release_tick(rb), .long_tick(lb), .repeat_tick(rpb), .held(hb)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: clocks since reset, ticks counted since the last event.
    int m_presc = 0;
    bit m_prev, m_held, m_long;
    int m_ticks;
    bit e_press, e_rel, e_long, e_rep;

    // Monitor of dut_a pulses, for ordering and timing checks.
    int cyc = 0;
    int cnt_press = 0, cnt_rel = 0, cnt_long = 0, cnt_rep = 0, cnt_held = 0;
    int cnt_long_b = 0, cnt_rep_b = 0;
    int press_cyc = 0, last_evt_cyc = 0;
    int last_rel_off = -1, last_long_off = -1, last_rep_gap = -1;
    bit sb_pressed = 1'b0, sb_long = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_presc = 0; m_prev = 0; m_held = 0; m_long = 0; m_ticks = 0;
                e_press = 0; e_rel = 0; e_long = 0; e_rep = 0;
                sb_pressed = 0; sb_long = 0;
            end else begin
                bit tick, rise, fall;
                tick = (m_presc % Period) == Period - 1;
                rise = key_mark && !m_prev;
                fall = !key_mark && m_prev;
                e_press = 0; e_rel = 0; e_long = 0; e_rep = 0;
                if (!m_held) begin
                    if (rise) begin
                        e_press = 1; m_held = 1; m_long = 0; m_ticks = 0;
                    end
                end else if (fall) begin
                    e_rel = 1; m_held = 0;
                end else if (tick) begin
                    m_ticks++;
                    if (!m_long && m_ticks == LT) begin
                        e_long = 1; m_long = 1; m_ticks = 0;
                    end else if (m_long && m_ticks == RT) begin
                        e_rep = 1; m_ticks = 0;
                    end
                end
                m_prev = key_mark;
                m_presc++;
            end
            #1;
            cyc++;
            check("dut_a outputs", {27'd0, pa, ra, la, rpa, ha},
                  {27'd0, e_press, e_rel, e_long, e_rep, m_held});
            check("dut_b outputs", {27'd0, pb, rb, lb, rpb, hb},
                  {27'd0, e_press, e_rel, e_long, 1'b0, m_held});
            if (pa === 1'b1) begin
                check("alternation press", {31'd0, sb_pressed}, 32'd0);
                sb_pressed = 1; sb_long = 0; cnt_press++;
                press_cyc = cyc; last_evt_cyc = cyc;
            end
            if (ra === 1'b1) begin
                check("alternation release", {31'd0, sb_pressed}, 32'd1);
                sb_pressed = 0; cnt_rel++;
                last_rel_off = cyc - press_cyc;
            end
            if (la === 1'b1) begin
                check("long once per press", {31'd0, sb_long}, 32'd0);
                sb_long = 1; cnt_long++;
                last_long_off = cyc - press_cyc; last_evt_cyc = cyc;
            end
            if (rpa === 1'b1) begin
                check("repeat after long", {31'd0, sb_long}, 32'd1);
                cnt_rep++;
                last_rep_gap = cyc - last_evt_cyc; last_evt_cyc = cyc;
            end
            if (lb === 1'b1) cnt_long_b++;
            if (rpb === 1'b1) cnt_rep_b++;
            if (ha === 1'b1) cnt_held++;
        end
    end

    int s_press, s_rel, s_long, s_rep, s_held, s_long_b, s_rep_b;

    task automatic snap();
        s_press = cnt_press; s_rel = cnt_rel; s_long = cnt_long; s_rep = cnt_rep;
        s_held = cnt_held; s_long_b = cnt_long_b; s_rep_b = cnt_rep_b;
    endtask

    // Align so the press edge sees prescaler value 0 (ticks land at +7, +15, ...).
    task automatic wait_phase();
        @(negedge clk);
        while ((m_presc % Period) != 0) @(negedge clk);
    endtask

    task automatic hold(input int n);
        wait_phase();
        snap();
        key_mark = 1'b1;
        repeat (n) @(negedge clk);
        key_mark = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        key_mark = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", {22'd0, pa, ra, la, rpa, ha, pb, rb, lb, rpb, hb}, 32'd0);
        reset = 1'b0;

        // Short hold: one press, one release 10 clocks later, nothing else.
        hold(10);
        check("t1 press count", cnt_press - s_press, 1);
        check("t1 release count", cnt_rel - s_rel, 1);
        check("t1 long count", cnt_long - s_long, 0);
        check("t1 repeat count", cnt_rep - s_rep, 0);
        check("t1 held clocks", cnt_held - s_held, 10);
        check("t1 release offset", last_rel_off, 10);

        // Long hold: long at +31, repeats at +47/+63/+79, release at +80.
        hold(80);
        check("t2 long count", cnt_long - s_long, 1);
        check("t2 long offset", last_long_off, 31);
        check("t2 repeat count", cnt_rep - s_rep, 3);
        check("t2 repeat spacing", last_rep_gap, 16);
        check("t2 release count", cnt_rel - s_rel, 1);
        check("t2 held clocks", cnt_held - s_held, 80);
        check("t3 long count no-repeat", cnt_long_b - s_long_b, 1);
        check("t3 repeat count no-repeat", cnt_rep_b - s_rep_b, 0);

        // Release on the very edge where the long tick would fire.
        hold(31);
        check("t4 long count", cnt_long - s_long, 0);
        check("t4 release count", cnt_rel - s_rel, 1);
        check("t4 release offset", last_rel_off, 31);
        check("t4 held after", {31'd0, ha}, 32'd0);

        // Reset while in the long-press state, key kept down.
        wait_phase();
        snap();
        key_mark = 1'b1;
        repeat (40) @(negedge clk);
        check("t5 held before reset", {31'd0, ha}, 32'd1);
        check("t5 long before reset", cnt_long - s_long, 1);
        #2 reset = 1'b1;
        #1 check("t5 async clear", {22'd0, pa, ra, la, rpa, ha, pb, rb, lb, rpb, hb}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #2 check("t5 press after reset", {31'd0, pa}, 32'd1);
        check("t5 no release", cnt_rel - s_rel, 0);
        repeat (5) @(negedge clk);
        key_mark = 1'b0;
        repeat (4) @(negedge clk);

        // Glitches: 1-clock and 3-clock pulses.
        hold(1);
        check("t6 glitch1 pair", (cnt_press - s_press) * 16 + (cnt_rel - s_rel), 17);
        check("t6 glitch1 spacing", last_rel_off, 1);
        hold(3);
        check("t6 glitch3 pair", (cnt_press - s_press) * 16 + (cnt_rel - s_rel), 17);
        check("t6 glitch3 spacing", last_rel_off, 3);

        // Random key runs with occasional resets, checked against the model.
        repeat (300) begin
            int len;
            len = $urandom_range(1, 60);
            key_mark = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            repeat (len) @(negedge clk);
        end
        key_mark = 1'b0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
